cic_comp_fir: RTL and testbench

//  Time-multiplexed FIR that sits directly downstream of the CIC decimator.

---
 rtl/cic_comp_fir.sv | 166 ++++++++++++++++
 tb/tb_cic_comp_fir.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// Droop-compensation FIR placed after the CIC decimator.
// A single registered multiplier feeds a serial MAC. Trigger samples are
// selected by an extra decimation phase counter. While the MAC runs, any
// input that arrives is dropped and the sticky overrun flag is raised.
// The result is rounded half-up, shifted, saturated and registered.
module cic_comp_fir #(
  parameter int INP_DW    = 32,
  parameter int OUT_DW    = 32,
  parameter int COEF_DW   = 18,
  parameter int NUM_TAPS  = 21,
  parameter logic [NUM_TAPS*COEF_DW-1:0] COEFS = '0,
  parameter int FIR_R     = 2,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [INP_DW-1:0] s_axis_in_tdata,
  input  logic                     s_axis_in_tvalid,
  output logic signed [OUT_DW-1:0] m_axis_out_tdata,
  output logic                     m_axis_out_tvalid,
  output logic                     overrun
);

  localparam int PROD_DW = INP_DW + COEF_DW;
  localparam int ACC_DW  = INP_DW + COEF_DW + $clog2(NUM_TAPS);
  // k counts 0..NUM_TAPS: one extra MAC cycle drains the product register.
  localparam int KW      = $clog2(NUM_TAPS + 1);
  localparam int AW      = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PW      = (FIR_R > 1) ? $clog2(FIR_R) : 1;
  // Rounding adds one guard bit so the rounding offset cannot overflow.
  localparam int RW      = ACC_DW + 1;
  localparam int SW      = ((RW > OUT_DW) ? RW : OUT_DW) + 1;
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [KW-1:0] K_LAST  = KW'(NUM_TAPS);
  localparam logic [PW-1:0] PH_LAST = PW'(FIR_R - 1);

  localparam logic signed [RW-1:0] RND = (OUT_SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
  localparam logic signed [SW-1:0] SAT_MAX =
    $signed({{(SW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN =
    $signed({{(SW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}});

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  function automatic logic signed [COEF_DW-1:0] coef_at(input logic [AW-1:0] idx);
    return $signed(COEFS[int'(idx)*COEF_DW +: COEF_DW]);
  endfunction

  function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_DW-1:0] a);
    logic signed [RW-1:0] e;
    e = RW'(a) + RND;
    return e >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [OUT_DW-1:0] saturate(input logic signed [RW-1:0] r);
    logic signed [SW-1:0] w;
    w = SW'(r);
    if (w > SAT_MAX)      return SAT_MAX[OUT_DW-1:0];
    else if (w < SAT_MIN) return SAT_MIN[OUT_DW-1:0];
    else                  return w[OUT_DW-1:0];
  endfunction

  logic [1:0]                state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic signed [ACC_DW-1:0]  acc_q, acc_d;
  logic signed [OUT_DW-1:0]  tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      ovr_q, ovr_d;
  logic                      shift_en;
  logic signed [INP_DW-1:0]  dl_q [NUM_TAPS];
  logic signed [PROD_DW-1:0] prod_q, prod_d;
  logic [AW-1:0]             tap_idx;
  logic                      issue;

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign overrun           = ovr_q;

  // Tap selection for the multiplier; the drain cycle issues nothing.
  always_comb begin
    issue   = (state_q == S_MAC) && (k_q < K_LAST);
    tap_idx = issue ? k_q[AW-1:0] : '0;
    prod_d  = PROD_DW'(dl_q[tap_idx]) * PROD_DW'(coef_at(tap_idx));
  end

  // Next-state logic: acceptance, phase, MAC sequencing, output formatting.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    ovr_d    = ovr_q;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_axis_in_tvalid) begin
          shift_en = 1'b1;
          phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
          if (phase_q == PH_LAST) begin
            state_d = S_MAC;
            k_d     = '0;
            acc_d   = '0;
          end
        end
      end
      S_MAC: begin
        if (s_axis_in_tvalid) ovr_d = 1'b1;
        // The product register holds the tap issued on the previous cycle.
        if (k_q != '0) acc_d = acc_q + ACC_DW'(prod_q);
        if (k_q == K_LAST) state_d = S_OUT;
        else               k_d     = k_q + 1'b1;
      end
      S_OUT: begin
        // The edge returning to IDLE still counts as busy.
        if (s_axis_in_tvalid) ovr_d = 1'b1;
        tdata_d  = saturate(round_shift(acc_q));
        tvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      phase_q  <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Delay line: index 0 holds the newest sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAPS; i++) dl_q[i] <= '0;
    end else if (shift_en) begin
      dl_q[0] <= s_axis_in_tdata;
      for (int i = 1; i < NUM_TAPS; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // Registered multiplier; only read by the MAC one cycle after an issue.
  always_ff @(posedge clk) begin
    if (issue) prod_q <= prod_d;
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir with four configurations:
//   u0: 5 taps {1,2,3,4,5}, FIR_R=1      u1: same taps, FIR_R=2
//   u2: 1 tap {1}, OUT_SHIFT=2           u3: 1 tap {5}, OUT_DW=8
module tb_cic_comp_fir;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [31:0] din [4];
  logic               vin [4];
  logic               vout [4];
  logic               ovr [4];
  logic signed [31:0] dout0, dout1, dout2;
  logic signed [7:0]  dout3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int npass = 0;

  typedef struct {
    longint d;
    int     c;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  cic_comp_fir #(.NUM_TAPS(5), .COEFS({18'd5, 18'd4, 18'd3, 18'd2, 18'd1}), .FIR_R(1), .OUT_SHIFT(0)) u0 (
    .clk(clk), .reset_n(rst_n), .s_axis_in_tdata(din[0]), .s_axis_in_tvalid(vin[0]),
    .m_axis_out_tdata(dout0), .m_axis_out_tvalid(vout[0]), .overrun(ovr[0]));
  cic_comp_fir #(.NUM_TAPS(5), .COEFS({18'd5, 18'd4, 18'd3, 18'd2, 18'd1}), .FIR_R(2), .OUT_SHIFT(0)) u1 (
    .clk(clk), .reset_n(rst_n), .s_axis_in_tdata(din[1]), .s_axis_in_tvalid(vin[1]),
    .m_axis_out_tdata(dout1), .m_axis_out_tvalid(vout[1]), .overrun(ovr[1]));
  cic_comp_fir #(.NUM_TAPS(1), .COEFS(18'd1), .FIR_R(1), .OUT_SHIFT(2)) u2 (
    .clk(clk), .reset_n(rst_n), .s_axis_in_tdata(din[2]), .s_axis_in_tvalid(vin[2]),
    .m_axis_out_tdata(dout2), .m_axis_out_tvalid(vout[2]), .overrun(ovr[2]));
  cic_comp_fir #(.OUT_DW(8), .NUM_TAPS(1), .COEFS(18'd5), .FIR_R(1), .OUT_SHIFT(0)) u3 (
    .clk(clk), .reset_n(rst_n), .s_axis_in_tdata(din[3]), .s_axis_in_tvalid(vin[3]),
    .m_axis_out_tdata(dout3), .m_axis_out_tvalid(vout[3]), .overrun(ovr[3]));

  function automatic int taps(input int u);
    return (u < 2) ? 5 : 1;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    nchk++;
    if (act == req) npass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic push(input int u, input longint d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic take(input int u, output exp_t e, output bit ok);
    ok = 1'b1;
    e.d = 0;
    e.c = 0;
    case (u)
      0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // One accepted-or-dropped input, then idle so the next input is 10 cycles later.
  // The accepting edge leaves cyc = A; the strobe is visible on the negedge with
  // cyc = A+taps+2 and is sampled by edge A+taps+3, i.e. taps+3 edges later.
  task automatic send(input int u, input logic signed [31:0] x, input bit trig, input longint expv);
    @(negedge clk);
    din[u] = x;
    vin[u] = 1'b1;
    @(posedge clk);
    #1;
    vin[u] = 1'b0;
    if (trig) push(u, expv, cyc + taps(u) + 2);
    repeat (9) @(posedge clk);
  endtask

  // Monitor: pop and compare whenever a DUT strobes an output.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int u = 0; u < 4; u++) begin
        if (vout[u]) begin
          exp_t   e;
          bit     ok;
          longint a;
          case (u)
            0: a = dout0;
            1: a = dout1;
            2: a = dout2;
            default: a = dout3;
          endcase
          take(u, e, ok);
          if (!ok) begin
            nchk++;
            $display("FAIL u%0d_unexpected_out: actual value %0d at cycle %0d, required no output", u, a, cyc);
          end else begin
            chk($sformatf("u%0d_data", u), a, e.d);
            chk($sformatf("u%0d_latency", u), cyc, e.c);
          end
        end
      end
    end
  end

  initial begin
    longint imp_r[6] = '{1, 2, 3, 4, 5, 0};
    longint dc_r[6]  = '{100, 300, 600, 1000, 1500, 1500};
    longint fl_r[5]  = '{1400, 1200, 900, 500, 0};
    longint dec_r[6] = '{0, 2, 0, 4, 0, 0};
    longint rx[5]    = '{3, -3, 6, -6, 5};
    longint rr[5]    = '{1, -1, 2, -1, 1};
    longint sx[5]    = '{100, -100, 25, -25, 26};
    longint sr[5]    = '{127, -128, 125, -125, 127};

    for (int u = 0; u < 4; u++) begin
      din[u] = '0;
      vin[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("u%0d_rst_tvalid", u), vout[u], 0);
      chk($sformatf("u%0d_rst_overrun", u), ovr[u], 0);
    end
    chk("u0_rst_tdata", dout0, 0);
    chk("u3_rst_tdata", dout3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Impulse response on u0.
    for (int i = 0; i < 6; i++) send(0, (i == 0) ? 32'sd1 : 32'sd0, 1'b1, imp_r[i]);
    // DC ramp-up to sum(h)*100.
    for (int i = 0; i < 6; i++) send(0, 32'sd100, 1'b1, dc_r[i]);
    // Decimation by 2: only every second sample triggers.
    for (int i = 0; i < 6; i++) send(1, (i == 0) ? 32'sd1 : 32'sd0, (i % 2) == 1, dec_r[i]);
    // Round half up with shift 2, then saturation to 8 bits.
    for (int i = 0; i < 5; i++) send(2, 32'(rx[i]), 1'b1, rr[i]);
    for (int i = 0; i < 5; i++) send(3, 32'(sx[i]), 1'b1, sr[i]);

    // Flush u0 with zeros, then two back-to-back inputs: the second is dropped.
    for (int i = 0; i < 5; i++) send(0, 32'sd0, 1'b1, fl_r[i]);
    chk("u0_overrun_before", ovr[0], 0);
    @(negedge clk);
    din[0] = 32'sd1;
    vin[0] = 1'b1;
    @(posedge clk);
    #1;
    push(0, 1, cyc + 7);
    din[0] = 32'sd7;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (9) @(posedge clk);
    chk("u0_overrun_set", ovr[0], 1);
    for (int i = 1; i < 5; i++) send(0, 32'sd0, 1'b1, imp_r[i]);
    chk("u0_overrun_sticky", ovr[0], 1);
    chk("u1_overrun_clear", ovr[1], 0);

    // Reset three cycles into the MAC: nothing comes out of that computation.
    @(negedge clk);
    din[0] = 32'sd9;
    vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("u0_midrst_tvalid", vout[0], 0);
    chk("u0_midrst_tdata", dout0, 0);
    chk("u0_midrst_overrun", ovr[0], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    for (int i = 0; i < 6; i++) send(0, (i == 0) ? 32'sd1 : 32'sd0, 1'b1, imp_r[i]);

    repeat (20) @(posedge clk);
    chk("u0_pending", q0.size(), 0);
    chk("u1_pending", q1.size(), 0);
    chk("u2_pending", q2.size(), 0);
    chk("u3_pending", q3.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
